// File: rtl/aes_inv_cipher_iter_if.sv
// Handshake/data bundle for the iterative AES inverse cipher.
//  AES_START    level request, sampled only while the core is idle
//  AES_MSG_ENC  ciphertext, byte0 = [127:120], column-major
//  RK_IDX       round-key index the core wants this cycle
//  RK_DATA      round key RK_IDX, valid combinationally in the same cycle
//  AES_BUSY     run in progress
//  AES_DONE     AES_MSG_DEC valid
//  AES_MSG_DEC  plaintext, registered
// master = register file / key-schedule side, slave = cipher core.
interface aes_inv_cipher_iter_if;
  logic         AES_START;
  logic [127:0] AES_MSG_ENC;
  logic [3:0]   RK_IDX;
  logic [127:0] RK_DATA;
  logic         AES_BUSY;
  logic         AES_DONE;
  logic [127:0] AES_MSG_DEC;

  modport master (
    output AES_START, AES_MSG_ENC, RK_DATA,
    input  RK_IDX, AES_BUSY, AES_DONE, AES_MSG_DEC
  );

  modport slave (
    input  AES_START, AES_MSG_ENC, RK_DATA,
    output RK_IDX, AES_BUSY, AES_DONE, AES_MSG_DEC
  );
endinterface

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher (AES-128/192/256), one transform per clock.
// Round keys are fetched from an external schedule through bus.RK_IDX /
// bus.RK_DATA (combinational return).
//  CLK      clock
//  RESET_N  asynchronous active-low reset
//  bus      aes_inv_cipher_iter_if.slave (start/ciphertext in, round-key
//           port, busy/done/plaintext out)
// Parameters:
//  KEY_BITS            128/192/256, NR = 6 + KEY_BITS/32
//  MIX_COLS_PER_CYCLE  1/2/4 InvMixColumns columns handled per IMC cycle
module aes_inv_cipher_iter #(
  parameter int KEY_BITS           = 128,
  parameter int MIX_COLS_PER_CYCLE = 1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  aes_inv_cipher_iter_if.slave  bus
);

  localparam int NR   = 6 + KEY_BITS / 32;
  localparam int CS   = (MIX_COLS_PER_CYCLE < 1) ? 1 : MIX_COLS_PER_CYCLE;
  localparam int NGRP = (4 / CS < 1) ? 1 : 4 / CS;
  localparam logic [3:0] NR4      = 4'(NR);
  localparam logic [3:0] NR4M1    = 4'(NR - 1);
  localparam logic [1:0] LAST_GRP = 2'(NGRP - 1);

  if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key
    $error("aes_inv_cipher_iter: KEY_BITS must be 128, 192 or 256");
  end
  if (!(MIX_COLS_PER_CYCLE == 1 || MIX_COLS_PER_CYCLE == 2 ||
        MIX_COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("aes_inv_cipher_iter: MIX_COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // GF(2^8) arithmetic, reduction polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction

  // Inverse S-box computed rather than tabled: undo the affine map, then
  // take the multiplicative inverse as b^254 = prod_{k=1..7} b^(2^k).
  // b = 0 falls out as 0 without a special case.
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b, sq, acc;
    b   = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    sq  = b;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  // Row r of the matrix is {0e,0b,0d,09} rotated right by r
  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0]  a [4];
    logic [31:0] o;
    for (int i = 0; i < 4; i++) a[i] = w[31-8*i -: 8];
    for (int r = 0; r < 4; r++)
      o[31-8*r -: 8] = gmul(a[r], 8'h0e)       ^ gmul(a[(r+1)%4], 8'h0b) ^
                       gmul(a[(r+2)%4], 8'h0d) ^ gmul(a[(r+3)%4], 8'h09);
    return o;
  endfunction

  typedef enum logic [2:0] {IDLE, ARK0, ISR, ISB, ARK, IMC, DONE} state_t;

  state_t       fsm_q;
  logic [127:0] st_q;
  logic [3:0]   round_q;
  logic [1:0]   col_q;
  logic [3:0]   rk_idx_q;
  logic         busy_q, done_q;
  logic [127:0] dec_q;

  logic [127:0] isr_d, isb_d, imc_d;

  // Byte (row r, col c) lives at index 4c+r; InvShiftRows takes it from
  // column (c-r) mod 4 of the same row.
  always_comb begin
    isr_d = '0;
    isb_d = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        isr_d[127-8*(4*c+r) -: 8] = st_q[127-8*(4*((c-r+4)%4)+r) -: 8];
        isb_d[127-8*(4*c+r) -: 8] = inv_sbox(st_q[127-8*(4*c+r) -: 8]);
      end
    end
  end

  // Only the column group selected by col_q is rewritten per IMC cycle
  for (genvar g = 0; g < 4; g++) begin : g_col
    logic sel;
    assign sel = (2'(g / CS) == col_q);
    assign imc_d[127-32*g -: 32] = sel ? inv_mix_col(st_q[127-32*g -: 32])
                                       : st_q[127-32*g -: 32];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fsm_q    <= IDLE;
      st_q     <= '0;
      round_q  <= '0;
      col_q    <= '0;
      rk_idx_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dec_q    <= '0;
    end else begin
      case (fsm_q)
        IDLE: if (bus.AES_START) begin
          st_q     <= bus.AES_MSG_ENC;
          round_q  <= NR4M1;
          rk_idx_q <= NR4;
          busy_q   <= 1'b1;
          fsm_q    <= ARK0;
        end
        ARK0: begin
          st_q     <= st_q ^ bus.RK_DATA;
          rk_idx_q <= round_q;
          fsm_q    <= ISR;
        end
        ISR: begin
          st_q  <= isr_d;
          fsm_q <= ISB;
        end
        ISB: begin
          st_q  <= isb_d;
          fsm_q <= ARK;
        end
        ARK: begin
          st_q <= st_q ^ bus.RK_DATA;
          if (round_q == 4'd0) begin
            // Final round has no InvMixColumns; publish the result here
            dec_q  <= st_q ^ bus.RK_DATA;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            fsm_q  <= DONE;
          end else begin
            col_q <= 2'd0;
            fsm_q <= IMC;
          end
        end
        IMC: begin
          st_q <= imc_d;
          if (col_q == LAST_GRP) begin
            col_q    <= 2'd0;
            round_q  <= round_q - 4'd1;
            rk_idx_q <= round_q - 4'd1;
            fsm_q    <= ISR;
          end else begin
            col_q <= col_q + 2'd1;
          end
        end
        DONE: if (!bus.AES_START) begin
          done_q <= 1'b0;
          fsm_q  <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign bus.RK_IDX      = rk_idx_q;
  assign bus.AES_BUSY    = busy_q;
  assign bus.AES_DONE    = done_q;
  assign bus.AES_MSG_DEC = dec_q;

endmodule
